// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch sequencing controller: FSM state, redirect and
// predictor-update bundles.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_ctrl_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        flush;
  } redirect_t;

  typedef struct packed {
    logic        valid;
    logic        value;
    logic [31:0] pc;
  } bp_update_t;

  // Wide enough for FLUSH_CYCLES-1 with FLUSH_CYCLES up to 15.
  localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/iq_credit_ctr.sv
// Instruction-queue occupancy counter: +1 per fire, -1 per pop, saturating at
// DEPTH; clear wins over both and discards that cycle's fire/pop.
module iq_credit_ctr #(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fire,
  input  logic          pop,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          full
);

  logic [CW-1:0] count_q, count_d;
  logic          fire_ok, pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign fire_ok = fire & ~full;
  // A pop against an empty queue has nothing to remove.
  assign pop_ok  = pop & (count_q != '0);
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (fire_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !fire_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  pop_underflow_a: assert property (@(posedge clk) disable iff (!reset)
    !(pop && !clear && count_q == '0));

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing: fetch enable, IQ occupancy, redirect arbitration and
// predictor updates. Define FETCH_CTRL_PERF_EN to add performance counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int IQ_DEPTH     = 8,
  parameter int FLUSH_CYCLES = 2,
  localparam int OCC_W = $clog2(IQ_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmt_valid,
  input  logic             cmt_mispredict,
  input  logic             cmt_taken,
  input  logic [31:0]      cmt_pc,
  input  logic [31:0]      cmt_target,
  input  logic             dec_redirect_valid,
  input  logic [31:0]      dec_redirect_pc,
  input  logic             iq_pop,
  output logic             fetch_enable,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             bp_update_valid,
  output logic             bp_update_value,
  output logic [31:0]      bp_update_pc,
  output logic [OCC_W-1:0] iq_occupancy
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_mispredicts,
  output logic [31:0]      perf_stall_cycles
`endif
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  fetch_ctrl_state_e       state_q, state_d;
  logic [FLUSH_CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  redirect_t               redirect_q, redirect_d;
  bp_update_t              bp_q, bp_d;
  logic                    mispredict, dec_take, fire, iq_full;

  assign mispredict = cmt_valid & cmt_mispredict;
  assign dec_take   = dec_redirect_valid & (state_q == RUN) & ~mispredict;
  // The redirect cycle itself never fetches: the PC is being reloaded.
  assign fire       = (state_q == RUN) & ~iq_full & ~redirect_q.valid;

  iq_credit_ctr #(
    .DEPTH (IQ_DEPTH)
  ) u_iq_credit_ctr (
    .clk   (clk),
    .reset (reset),
    .fire  (fire),
    .pop   (iq_pop),
    .clear (mispredict),
    .count (iq_occupancy),
    .full  (iq_full)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (mispredict) begin
      state_d     = FLUSH;
      flush_cnt_d = FLUSH_LOAD;
    end else begin
      case (state_q)
        BOOT:  state_d = RUN;
        FLUSH: begin
          if (flush_cnt_q == '0) state_d = RUN;
          else                   flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
        end
        default: ;
      endcase
    end

    redirect_d.valid = mispredict | dec_take;
    redirect_d.flush = mispredict;
    redirect_d.pc    = mispredict ? cmt_target :
                       dec_take   ? dec_redirect_pc : redirect_q.pc;

    bp_d.valid = cmt_valid;
    bp_d.value = cmt_valid ? cmt_taken : bp_q.value;
    bp_d.pc    = cmt_valid ? cmt_pc    : bp_q.pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= BOOT;
      flush_cnt_q <= '0;
      redirect_q  <= '0;
      bp_q        <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      redirect_q  <= redirect_d;
      bp_q        <= bp_d;
    end
  end

  assign fetch_enable    = fire;
  assign redirect_valid  = redirect_q.valid;
  assign redirect_pc     = redirect_q.pc;
  assign flush           = redirect_q.flush;
  assign bp_update_valid = bp_q.valid;
  assign bp_update_value = bp_q.value;
  assign bp_update_pc    = bp_q.pc;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_mispredicts_q, perf_mispredicts_d;
  logic [31:0] perf_stall_cycles_q, perf_stall_cycles_d;

  always_comb begin
    perf_mispredicts_d  = perf_mispredicts_q + (mispredict ? 32'd1 : 32'd0);
    perf_stall_cycles_d = perf_stall_cycles_q +
                          (((state_q == RUN) && iq_full) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_mispredicts_q  <= '0;
      perf_stall_cycles_q <= '0;
    end else begin
      perf_mispredicts_q  <= perf_mispredicts_d;
      perf_stall_cycles_q <= perf_stall_cycles_d;
    end
  end

  assign perf_mispredicts  = perf_mispredicts_q;
  assign perf_stall_cycles = perf_stall_cycles_q;
`endif

endmodule
